fifo1c_rr_drain: RTL and testbench

// Round-robin drain scheduler for NUM_SRC single-clock fifo1c instances sharing one downstream

---
 rtl/fifo1c_rr_drain_pkg.sv | 22 ++
 rtl/fifo1c_rr_drain_if.sv | 27 ++
 rtl/fifo1c_rr_drain_rr_pick.sv | 30 +++
 rtl/fifo1c_rr_drain.sv | 183 ++++++++++++++++++
 tb/tb_fifo1c_rr_drain.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo1c_rr_drain_pkg.sv
// rtl/fifo1c_rr_drain_pkg.sv - shared types for the fifo1c round-robin drain scheduler
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } drain_st_e;

    // Widest source id the in-flight record has to carry (NUM_SRC <= 16).
    localparam int MAX_SRC_W = 4;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_SRC_W-1:0] src;
    } flight_t;

endpackage

// File: rtl/fifo1c_rr_drain_if.sv
// rtl/fifo1c_rr_drain_if.sv - source-FIFO and downstream-sink signals of the drain scheduler
interface fifo1c_rr_drain_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SRC_W      = fifo_drain_pkg::src_w(NUM_SRC)
);
    logic [NUM_SRC-1:0]            fifo_empty;
    logic [NUM_SRC*DATA_WIDTH-1:0] fifo_q;
    logic [NUM_SRC-1:0]            fifo_uflow;
    logic [NUM_SRC-1:0]            fifo_rdreq;
    logic                          dn_afull;
    logic                          dn_valid;
    logic [DATA_WIDTH-1:0]         dn_data;
    logic [SRC_W-1:0]              dn_src;
    logic                          busy;
    logic                          err_uflow;

    modport master (
        input  fifo_empty, fifo_q, fifo_uflow, dn_afull,
        output fifo_rdreq, dn_valid, dn_data, dn_src, busy, err_uflow
    );

    modport slave (
        output fifo_empty, fifo_q, fifo_uflow, dn_afull,
        input  fifo_rdreq, dn_valid, dn_data, dn_src, busy, err_uflow
    );
endinterface

// File: rtl/fifo1c_rr_drain_rr_pick.sv
// rtl/fifo1c_rr_drain_rr_pick.sv - combinational first-set picker starting at a rotating pointer
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [SRC_W-1:0]   o_gnt,
    output logic               o_gnt_vld
);
    int w_idx;

    // Walk from the far end back to the pointer so the nearest requester is written last.
    always_comb begin
        o_gnt     = '0;
        o_gnt_vld = 1'b0;
        w_idx     = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            if (i_req[w_idx]) begin
                o_gnt     = SRC_W'(w_idx);
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo1c_rr_drain.sv
// rtl/fifo1c_rr_drain.sv - round-robin drain of NUM_SRC fifo1c sources into one tagged sink
module fifo1c_rr_drain
    import fifo_drain_pkg::*;
#(
    parameter int  NUM_SRC    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  RD_LAT     = 1,
    parameter int  MAX_BURST  = 4,
    localparam int SRC_W      = src_w(NUM_SRC)
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo1c_rr_drain_if.master bus
);
    localparam int               PIPE_N    = (RD_LAT > 0) ? RD_LAT : 1;
    localparam logic [7:0]       BURST_LIM = 8'(MAX_BURST);
    localparam logic [SRC_W-1:0] LAST_ID   = SRC_W'(NUM_SRC - 1);

    drain_st_e              r_state, w_state_nxt;
    logic [SRC_W-1:0]       r_grant, w_grant_nxt;
    logic [SRC_W-1:0]       r_ptr, w_ptr_nxt;
    logic [SRC_W-1:0]       w_pick_id, w_rel_ptr;
    logic                   w_pick_vld;
    logic [7:0]             r_burst, w_burst_nxt, w_burst_inc;
    logic [NUM_SRC-1:0]     w_req, w_rdreq;
    logic                   w_g_empty, w_rd, w_inflight;
    flight_t                w_issue, w_cap;
    flight_t                r_pipe [PIPE_N];
    logic [DATA_WIDTH-1:0]  w_cap_data, r_dn_data;
    logic [SRC_W-1:0]       w_cap_id, r_dn_src;
    logic                   r_dn_valid, r_err_uflow;

    assign w_req = ~bus.fifo_empty;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_pick_id),
        .o_gnt_vld (w_pick_vld)
    );

    assign w_g_empty   = bus.fifo_empty[r_grant];
    assign w_rel_ptr   = (r_grant == LAST_ID) ? '0 : r_grant + SRC_W'(1);
    assign w_burst_inc = r_burst + 8'd1;

    always_comb begin
        w_rdreq = '0;
        if (r_state == RUN && !w_g_empty && !bus.dn_afull) begin
            w_rdreq[r_grant] = 1'b1;
        end
    end

    assign w_rd = |w_rdreq;

    // An emptied grant releases before backpressure is considered.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_burst_nxt = r_burst;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt = w_pick_id;
                    w_burst_nxt = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_g_empty) begin
                    w_ptr_nxt   = w_rel_ptr;
                    w_state_nxt = IDLE;
                end else if (bus.dn_afull) begin
                    w_state_nxt = PAUSE;
                end else begin
                    w_burst_nxt = w_burst_inc;
                    if (w_burst_inc == BURST_LIM) begin
                        w_ptr_nxt   = w_rel_ptr;
                        w_state_nxt = IDLE;
                    end
                end
            end
            PAUSE: begin
                if (w_g_empty) begin
                    w_ptr_nxt   = w_rel_ptr;
                    w_state_nxt = IDLE;
                end else if (!bus.dn_afull) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_burst <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_burst <= w_burst_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_issue       = '0;
        w_issue.valid = w_rd;
        w_issue.src   = MAX_SRC_W'(r_grant);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_N; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < PIPE_N; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // With a zero-latency source q is valid in the issue cycle, so capture straight from the issue.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_cap      = w_issue;
            assign w_inflight = 1'b0;
        end else begin : g_latn
            assign w_cap = r_pipe[PIPE_N-1];
            always_comb begin
                w_inflight = 1'b0;
                for (int i = 0; i < PIPE_N; i++) begin
                    w_inflight = w_inflight | r_pipe[i].valid;
                end
            end
        end
    endgenerate

    always_comb begin
        w_cap_data = '0;
        w_cap_id   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_cap.src == MAX_SRC_W'(i)) begin
                w_cap_data = bus.fifo_q[i*DATA_WIDTH +: DATA_WIDTH];
                w_cap_id   = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dn_valid  <= 1'b0;
            r_dn_data   <= '0;
            r_dn_src    <= '0;
            r_err_uflow <= 1'b0;
        end else begin
            r_dn_valid <= w_cap.valid;
            if (w_cap.valid) begin
                r_dn_data <= w_cap_data;
                r_dn_src  <= w_cap_id;
            end
            if (|bus.fifo_uflow) begin
                r_err_uflow <= 1'b1;
            end
        end
    end

    assign bus.fifo_rdreq = w_rdreq;
    assign bus.dn_valid   = r_dn_valid;
    assign bus.dn_data    = r_dn_data;
    assign bus.dn_src     = r_dn_src;
    assign bus.err_uflow  = r_err_uflow;
    assign bus.busy       = (r_state != IDLE) | w_inflight | r_dn_valid;

endmodule

// File: tb/tb_fifo1c_rr_drain.sv
// tb/tb_fifo1c_rr_drain.sv - directed self-checking bench for fifo1c_rr_drain
`timescale 1ns/1ps
module tb_fifo1c_rr_drain;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo1c_rr_drain_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .SRC_W(SW)) bus ();

    fifo1c_rr_drain #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .RD_LAT     (1),
        .MAX_BURST  (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef logic [DW-1:0] word_q_t[$];
    word_q_t        mem [NS];
    logic [DW-1:0]  q_reg [NS] = '{default: '0};
    logic [NS-1:0]  m_empty = '1;
    logic [NS-1:0]  m_uflow = '0;
    logic [NS-1:0]  m_rd;
    logic           m_afull = 1'b0;
    logic [9:0]     got [$];
    logic [9:0]     exp_q [$];
    logic           log_en = 1'b0;
    logic [15:0]    rd_log = '0;
    logic [15:0]    dv_log = '0;
    int             n_cmp = 0;
    int             n_err = 0;
    int             n_viol = 0;

    assign bus.fifo_empty = m_empty;
    assign bus.fifo_uflow = m_uflow;
    assign bus.dn_afull   = m_afull;
    assign bus.fifo_q     = {q_reg[3], q_reg[2], q_reg[1], q_reg[0]};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] w(input int s, input int k);
        return DW'(s * 16 + k);
    endfunction

    task automatic upd_empty();
        for (int i = 0; i < NS; i++) begin
            m_empty[i] = (mem[i].size() == 0);
        end
    endtask

    task automatic push(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            mem[s].push_back(w(s, k));
        end
        upd_empty();
    endtask

    task automatic expect_beats(input int s, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            exp_q.push_back({2'(s), w(s, k)});
        end
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_cnt"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        got.delete();
        exp_q.delete();
    endtask

    // Source FIFO model: registered q, one-cycle rdreq-to-q latency.
    always @(posedge clk) begin
        m_rd = bus.fifo_rdreq;
        #1;
        for (int i = 0; i < NS; i++) begin
            if (m_rd[i] && mem[i].size() > 0) begin
                q_reg[i] = mem[i].pop_front();
            end
        end
        upd_empty();
    end

    always @(negedge clk) begin
        if (bus.dn_valid) begin
            got.push_back({bus.dn_src, bus.dn_data});
        end
        if ((bus.fifo_rdreq & bus.fifo_empty) != '0 || !$onehot0(bus.fifo_rdreq)) begin
            n_viol++;
        end
        if (log_en) begin
            rd_log = {rd_log[14:0], |bus.fifo_rdreq};
            dv_log = {dv_log[14:0], bus.dn_valid};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0", n_cmp);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdreq", 32'(bus.fifo_rdreq), 32'd0);
        chk("rst_dn_valid", 32'(bus.dn_valid), 32'd0);
        chk("rst_dn_data", 32'(bus.dn_data), 32'd0);
        chk("rst_dn_src", 32'(bus.dn_src), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err_uflow), 32'd0);
        #2 rst_n = 1'b1;

        // Test 1: single source, bursts 4,4,2 with one idle cycle between grants.
        do_reset();
        @(negedge clk);
        #2;
        push(0, 10);
        expect_beats(0, 0, 10);
        rd_log = '0;
        dv_log = '0;
        log_en = 1'b1;
        repeat (16) @(negedge clk);
        #2 log_en = 1'b0;
        chk("t1_rd_pattern", 32'(rd_log), 32'(16'b1111_0111_1011_0000));
        chk("t1_dv_pattern", 32'(dv_log), 32'(16'b0011_1101_1110_1100));
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        check_sb("t1");

        // Test 2: all sources hold two words, served 0..3 in turn.
        do_reset();
        @(negedge clk);
        #2;
        for (int s = 0; s < NS; s++) begin
            push(s, 2);
            expect_beats(s, 0, 2);
        end
        wait_drain("t2");
        check_sb("t2");
        chk("t2_all_empty", 32'(m_empty), 32'hF);

        // Test 3: backpressure mid-burst on src1.
        do_reset();
        @(negedge clk);
        #2;
        push(1, 8);
        expect_beats(1, 0, 8);
        repeat (3) @(negedge clk);
        #2 m_afull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_paused%0d", i), 32'(bus.fifo_rdreq), 32'd0);
        end
        #2 m_afull = 1'b0;
        @(negedge clk);
        chk("t3_resume", 32'(bus.fifo_rdreq), 32'b0010);
        wait_drain("t3");
        check_sb("t3");

        // Test 4: src0 and src2 fill while src3 holds the grant; pointer wraps to 0.
        do_reset();
        @(negedge clk);
        #2;
        push(3, 3);
        expect_beats(3, 0, 3);
        @(negedge clk);
        #2;
        push(0, 2);
        push(2, 2);
        expect_beats(0, 0, 2);
        expect_beats(2, 0, 2);
        wait_drain("t4");
        check_sb("t4");

        // Test 6: outputs hold the last beat, then a one-cycle underflow makes err_uflow sticky.
        @(negedge clk);
        chk("t6_hold_data", 32'(bus.dn_data), 32'h21);
        chk("t6_hold_src", 32'(bus.dn_src), 32'd2);
        chk("t6_err_pre", 32'(bus.err_uflow), 32'd0);
        #2 m_uflow = 4'b0100;
        @(negedge clk);
        #2 m_uflow = '0;
        @(negedge clk);
        chk("t6_err_set", 32'(bus.err_uflow), 32'd1);
        repeat (5) @(negedge clk);
        chk("t6_err_sticky", 32'(bus.err_uflow), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_err_rst", 32'(bus.err_uflow), 32'd0);
        chk("t6_data_rst", 32'(bus.dn_data), 32'd0);
        chk("t6_src_rst", 32'(bus.dn_src), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_err_after", 32'(bus.err_uflow), 32'd0);

        // Test 5: reset with two reads in flight drops them; the rest drains afterwards.
        do_reset();
        @(negedge clk);
        #2;
        push(0, 6);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        got.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("t5_valid%0d", i), 32'(bus.dn_valid), 32'd0);
            chk($sformatf("t5_rdreq%0d", i), 32'(bus.fifo_rdreq), 32'd0);
            chk($sformatf("t5_busy%0d", i), 32'(bus.busy), 32'd0);
            chk($sformatf("t5_src%0d", i), 32'(bus.dn_src), 32'd0);
        end
        #2 rst_n = 1'b1;
        expect_beats(0, 2, 4);
        wait_drain("t5");
        check_sb("t5");

        chk("rdreq_rules", 32'(n_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
